paddle_ctrl: RTL and testbench

//  Upstream of the ball stage: turns four raw push-buttons into paddle1_y/paddle2_y top-edge positions.
//  Per-button 2-FF sync + debounce, then a move by PADDLE_SPEED per refresh_tick, clamped to the playfield.

---
 rtl/pong_pkg.sv | 51 +++++
 rtl/paddle_ctrl_debounce.sv | 45 ++++
 rtl/paddle_ctrl.sv | 105 ++++++++++
 tb/tb_paddle_ctrl.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared pong geometry, position type and the paddle step/clamp helper.
package pong_pkg;

  localparam int SCREEN_W     = 640;
  localparam int SCREEN_H     = 480;
  localparam int PADDLE_H     = 72;
  localparam int BALL_SIZE    = 8;
  localparam int PADDLE_Y_MAX = SCREEN_H - PADDLE_H;

  // Paddle column bounds, shared with the ball stage and the renderer
  localparam int P1_X_MIN = 32;
  localparam int P1_X_MAX = 40;
  localparam int P2_X_MIN = 600;
  localparam int P2_X_MAX = 608;

  typedef logic [9:0] pos_t;

  typedef enum logic [1:0] {
    MOVE_NONE,
    MOVE_UP,
    MOVE_DOWN
  } move_t;

  function automatic move_t decode_move(logic up, logic down);
    move_t m;
    m = MOVE_NONE;
    if (up && !down)
      m = MOVE_UP;
    else if (down && !up)
      m = MOVE_DOWN;
    return m;
  endfunction

  // 11-bit arithmetic so the downward sum cannot wrap before the clamp
  function automatic pos_t step_pos(pos_t y, move_t dir, logic [10:0] step,
                                    logic [10:0] ymax);
    logic [10:0] y11;
    logic [10:0] sum;
    pos_t        res;
    y11 = {1'b0, y};
    sum = y11 + step;
    res = y;
    case (dir)
      MOVE_UP:   res = (y11 < step) ? 10'd0 : pos_t'(y11 - step);
      MOVE_DOWN: res = (sum > ymax) ? pos_t'(ymax) : pos_t'(sum);
      default:   res = y;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/paddle_ctrl_debounce.sv
// button_debounce: 2-FF synchroniser followed by a stability counter.
module button_debounce #(
  parameter int DB_CYCLES = 250000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic level
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Counter only advances while the synced input disagrees with the accepted level
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (sync2 != level) begin
      if (cnt == CNT_LAST) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else begin
      cnt <= '0;
    end
  end

endmodule

// File: rtl/paddle_ctrl.sv
// paddle_ctrl: debounced buttons move two paddles once per refresh tick, clamped to the playfield.
// Define PADDLE_AI_EN to let a ball-tracking CPU drive paddle 2 from ball_y.
module paddle_ctrl
  import pong_pkg::*;
#(
  parameter int SCREEN_H     = 480,
  parameter int PADDLE_H     = 72,
  parameter int PADDLE_SPEED = 4,
  parameter int Y_INIT       = 204,
  parameter int DB_CYCLES    = 250000,
  parameter int AI_SPEED     = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       refresh_tick,
  input  logic       p1_up,
  input  logic       p1_down,
  input  logic       p2_up,
  input  logic       p2_down,
  input  logic       hold,
  input  logic       recenter,
`ifdef PADDLE_AI_EN
  input  logic [9:0] ball_y,
`endif
  output logic [9:0] paddle1_y,
  output logic [9:0] paddle2_y,
  output logic       p1_moving,
  output logic       p2_moving
);

  localparam logic [10:0] YMAX     = 11'(SCREEN_H - PADDLE_H);
  localparam logic [10:0] SPEED    = 11'(PADDLE_SPEED);
  localparam pos_t        Y_START  = pos_t'(Y_INIT);

  logic p1_up_db, p1_down_db, p2_up_db, p2_down_db;

  button_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_p1_up (
    .clk(clk), .reset_n(reset_n), .raw(p1_up), .level(p1_up_db));
  button_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_p1_down (
    .clk(clk), .reset_n(reset_n), .raw(p1_down), .level(p1_down_db));
  button_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_p2_up (
    .clk(clk), .reset_n(reset_n), .raw(p2_up), .level(p2_up_db));
  button_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_p2_down (
    .clk(clk), .reset_n(reset_n), .raw(p2_down), .level(p2_down_db));

  pos_t p1_next;
  pos_t p2_next;

  assign p1_next = step_pos(paddle1_y, decode_move(p1_up_db, p1_down_db), SPEED, YMAX);

`ifdef PADDLE_AI_EN
  localparam logic [10:0] AI_STEP  = 11'(AI_SPEED);
  localparam logic [10:0] HALF_PAD = 11'(PADDLE_H / 2);

  logic [10:0] p2_center;
  logic [10:0] ball11;
  logic        ai_up;
  logic        ai_down;

  // Deadband of +/-AI_SPEED around the paddle centre keeps the CPU from jittering
  assign p2_center = {1'b0, paddle2_y} + HALF_PAD;
  assign ball11    = {1'b0, ball_y};
  assign ai_up     = (ball11 + AI_STEP) < p2_center;
  assign ai_down   = ball11 > (p2_center + AI_STEP);
  assign p2_next   = step_pos(paddle2_y, decode_move(ai_up, ai_down), AI_STEP, YMAX);
`else
  assign p2_next   = step_pos(paddle2_y, decode_move(p2_up_db, p2_down_db), SPEED, YMAX);
`endif

  // Recenter wins over everything and does not need a tick; hold only freezes on ticks
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      paddle1_y <= Y_START;
      p1_moving <= 1'b0;
    end else if (recenter) begin
      paddle1_y <= Y_START;
      p1_moving <= 1'b0;
    end else if (refresh_tick) begin
      if (hold) begin
        p1_moving <= 1'b0;
      end else begin
        paddle1_y <= p1_next;
        p1_moving <= (p1_next != paddle1_y);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      paddle2_y <= Y_START;
      p2_moving <= 1'b0;
    end else if (recenter) begin
      paddle2_y <= Y_START;
      p2_moving <= 1'b0;
    end else if (refresh_tick) begin
      if (hold) begin
        p2_moving <= 1'b0;
      end else begin
        paddle2_y <= p2_next;
        p2_moving <= (p2_next != paddle2_y);
      end
    end
  end

endmodule

// File: tb/tb_paddle_ctrl.sv
// Directed bench for paddle_ctrl with a 4-clock debounce; AI checks run when PADDLE_AI_EN is defined.
module tb_paddle_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       refresh_tick = 1'b0;
  logic       p1_up = 1'b0, p1_down = 1'b0, p2_up = 1'b0, p2_down = 1'b0;
  logic       hold = 1'b0;
  logic       recenter = 1'b0;
  logic [9:0] paddle1_y, paddle2_y;
  logic       p1_moving, p2_moving;
`ifdef PADDLE_AI_EN
  logic [9:0] ball_y = 10'd0;
`endif

  int checks = 0;
  int failures = 0;
  int exp_y;
  int prev_y;

  paddle_ctrl #(.DB_CYCLES(4)) dut (
    .clk(clk), .reset_n(reset_n), .refresh_tick(refresh_tick),
    .p1_up(p1_up), .p1_down(p1_down), .p2_up(p2_up), .p2_down(p2_down),
    .hold(hold), .recenter(recenter),
`ifdef PADDLE_AI_EN
    .ball_y(ball_y),
`endif
    .paddle1_y(paddle1_y), .paddle2_y(paddle2_y),
    .p1_moving(p1_moving), .p2_moving(p2_moving));

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int got, input int expected);
    checks++;
    if (got !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, expected);
    end
  endtask

  // One clock with the given tick/recenter levels; returns on the following negedge
  task automatic applyStimulus(input logic tick_i, input logic rc_i);
    @(negedge clk);
    refresh_tick = tick_i;
    recenter     = rc_i;
    @(negedge clk);
    refresh_tick = 1'b0;
    recenter     = 1'b0;
  endtask

  task automatic waitClocks(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic int modelStep(input int y, input int dir);
    int r;
    r = y;
    if (dir < 0) r = (y < 4) ? 0 : y - 4;
    if (dir > 0) r = (y + 4 > 408) ? 408 : y + 4;
    return r;
  endfunction

  initial begin
    #1 reset_n = 1'b0;
    #1;
    checkOutput("rst_p1_y", paddle1_y, 204);
    checkOutput("rst_p2_y", paddle2_y, 204);
    checkOutput("rst_p1_mv", p1_moving, 0);
    checkOutput("rst_p2_mv", p2_moving, 0);
    waitClocks(3);
    reset_n = 1'b1;

    // Player 1 up to the top edge and beyond
    p1_up = 1'b1;
    waitClocks(8);
    exp_y = 204;
    for (int i = 0; i < 60; i++) begin
      applyStimulus(1'b1, 1'b0);
      prev_y = exp_y;
      exp_y  = modelStep(exp_y, -1);
      checkOutput("p1_up_y", paddle1_y, exp_y);
      checkOutput("p1_up_mv", p1_moving, int'(exp_y != prev_y));
    end
    checkOutput("p1_top", paddle1_y, 0);

    // Asynchronous reset mid-cycle while moving
    p1_up = 1'b0;
    p1_down = 1'b1;
    waitClocks(8);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("pre_rst_y", paddle1_y, 8);
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    checkOutput("async_p1_y", paddle1_y, 204);
    checkOutput("async_p1_mv", p1_moving, 0);
    checkOutput("async_p2_y", paddle2_y, 204);
    p1_down = 1'b0;
    waitClocks(2);
    reset_n = 1'b1;
    waitClocks(2);

`ifndef PADDLE_AI_EN
    // Player 2 down into the bottom clamp: ...400, 404, 408, 408
    p2_down = 1'b1;
    waitClocks(8);
    exp_y = 204;
    for (int i = 0; i < 52; i++) begin
      applyStimulus(1'b1, 1'b0);
      prev_y = exp_y;
      exp_y  = modelStep(exp_y, 1);
      checkOutput("p2_dn_y", paddle2_y, exp_y);
      checkOutput("p2_dn_mv", p2_moving, int'(exp_y != prev_y));
    end
    checkOutput("p2_bottom", paddle2_y, 408);
    p2_down = 1'b0;
    waitClocks(8);
`endif

    // Short glitch is dropped, long press is accepted
    p1_down = 1'b1;
    waitClocks(3);
    p1_down = 1'b0;
    waitClocks(8);
    applyStimulus(1'b1, 1'b0);
    checkOutput("glitch_y", paddle1_y, 204);
    checkOutput("glitch_mv", p1_moving, 0);
    p1_down = 1'b1;
    waitClocks(6);
    applyStimulus(1'b1, 1'b0);
    checkOutput("press_y", paddle1_y, 208);
    checkOutput("press_mv", p1_moving, 1);

    // Hold freezes the paddle
    p1_down = 1'b0;
    p1_up = 1'b1;
    waitClocks(8);
    hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b0);
      checkOutput("hold_y", paddle1_y, 208);
      checkOutput("hold_mv", p1_moving, 0);
    end
    hold = 1'b0;
    exp_y = 208;
    for (int i = 0; i < 27; i++) begin
      applyStimulus(1'b1, 1'b0);
      exp_y = modelStep(exp_y, -1);
    end
    checkOutput("at_100_y", paddle1_y, 100);

    // Recenter with and without a tick
    applyStimulus(1'b1, 1'b1);
    checkOutput("rc_tick_y", paddle1_y, 204);
    checkOutput("rc_tick_mv", p1_moving, 0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("after_rc_y", paddle1_y, 200);
    applyStimulus(1'b0, 1'b1);
    checkOutput("rc_only_y", paddle1_y, 204);

    // Both buttons pressed: no move
    p1_down = 1'b1;
    waitClocks(8);
    applyStimulus(1'b1, 1'b0);
    checkOutput("both_y", paddle1_y, 204);
    checkOutput("both_mv", p1_moving, 0);
    p1_up = 1'b0;
    p1_down = 1'b0;

`ifdef PADDLE_AI_EN
    applyStimulus(1'b0, 1'b1);
    ball_y = 10'd100;
    applyStimulus(1'b1, 1'b0);
    checkOutput("ai_up1", paddle2_y, 202);
    applyStimulus(1'b1, 1'b0);
    checkOutput("ai_up2", paddle2_y, 200);
    applyStimulus(1'b0, 1'b1);
    ball_y = 10'd241;
    applyStimulus(1'b1, 1'b0);
    checkOutput("ai_dead_y", paddle2_y, 204);
    checkOutput("ai_dead_mv", p2_moving, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
